// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
// State encoding and default operand width.
package subtractor_defs;

   localparam int unsigned WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/serial_subtractor_ctrl_fs_bit.sv
// One-bit full-subtractor cell: d = a - b - bin, bo = borrow out.
// Purely combinational.
module fs_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bin;
   assign bo = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one fs_bit cell walked LSB first,
// borrow carried between cycles in a flop, start/busy/done handshake.
module serial_subtractor_ctrl
   import subtractor_defs::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sa_q, sb_q, res_q, res_n;
   logic [WIDTH-1:0] diff_q;
   logic             brw_q, bout_q, busy_q, done_q;
   logic             d_bit, bo_bit;

   fs_bit u_cell (
      .a   (sa_q[0]),
      .b   (sb_q[0]),
      .bin (brw_q),
      .d   (d_bit),
      .bo  (bo_bit)
   );

   // New result bit enters from the MSB side.
   if (WIDTH == 1) begin : g_w1
      assign res_n = d_bit;
   end else begin : g_wn
      assign res_n = {d_bit, res_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: state_d = start ? S_SHIFT : S_IDLE;
         S_SHIFT:        if (cnt_q == LAST) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         brw_q   <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == S_SHIFT);
         done_q  <= (state_d == S_DONE);
         if (state_q == S_SHIFT) begin
            sa_q  <= sa_q >> 1;
            sb_q  <= sb_q >> 1;
            res_q <= res_n;
            brw_q <= bo_bit;
            cnt_q <= cnt_q + 1'b1;
            if (state_d == S_DONE) begin
               diff_q <= res_n;
               bout_q <= bo_bit;
            end
         end else if (state_d == S_SHIFT) begin
            sa_q  <= a;
            sb_q  <= b;
            brw_q <= bin;
            cnt_q <= '0;
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and swept checks of serial_subtractor_ctrl at
// WIDTH = 1, 5 and 8.
module tb_serial_subtractor_ctrl;

   logic       clk;
   logic       rst;
   logic       st [3];
   logic [7:0] av [3];
   logic [7:0] bv [3];
   logic       bi [3];
   logic       bz [3];
   logic       dn [3];
   logic       bo [3];
   logic [0:0] df1;
   logic [4:0] df5;
   logic [7:0] df8;

   int nvec = 0;
   int nerr = 0;

   serial_subtractor_ctrl #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .start(st[0]),
      .a(av[0][0:0]), .b(bv[0][0:0]), .bin(bi[0]),
      .busy(bz[0]), .done(dn[0]), .diff(df1), .bout(bo[0])
   );

   serial_subtractor_ctrl #(.WIDTH(5)) u_w5 (
      .clk(clk), .rst(rst), .start(st[1]),
      .a(av[1][4:0]), .b(bv[1][4:0]), .bin(bi[1]),
      .busy(bz[1]), .done(dn[1]), .diff(df5), .bout(bo[1])
   );

   serial_subtractor_ctrl #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .start(st[2]),
      .a(av[2]), .b(bv[2]), .bin(bi[2]),
      .busy(bz[2]), .done(dn[2]), .diff(df8), .bout(bo[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] get_diff(int k);
      case (k)
         0:       return {7'd0, df1};
         1:       return {3'd0, df5};
         default: return df8;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start one operation on DUT k and wait (bounded) for done.
   task automatic run_op(input int k, input logic [7:0] a,
                         input logic [7:0] b, input logic bin,
                         output logic [7:0] d, output logic bout,
                         output int lat);
      st[k] = 1'b1;
      av[k] = a;
      bv[k] = b;
      bi[k] = bin;
      tick();
      st[k] = 1'b0;
      lat = 0;
      while (!dn[k] && lat < 40) begin
         tick();
         lat++;
      end
      d    = get_diff(k);
      bout = bo[k];
   endtask

   task automatic test_reset();
      nvec++;
      if (bz[2] !== 1'b0) begin
         nerr++;
         $display("FAIL reset_busy got %b want 0", bz[2]);
      end
      nvec++;
      if (dn[2] !== 1'b0) begin
         nerr++;
         $display("FAIL reset_done got %b want 0", dn[2]);
      end
      nvec++;
      if (df8 !== 8'h00) begin
         nerr++;
         $display("FAIL reset_diff got %h want 00", df8);
      end
      nvec++;
      if (bo[2] !== 1'b0) begin
         nerr++;
         $display("FAIL reset_bout got %b want 0", bo[2]);
      end
   endtask

   task automatic test_basic();
      int bad;
      st[2] = 1'b1;
      av[2] = 8'h5A;
      bv[2] = 8'h3C;
      bi[2] = 1'b0;
      tick();
      st[2] = 1'b0;
      av[2] = 8'h00;
      bv[2] = 8'hFF;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (bz[2] !== 1'b1 || dn[2] !== 1'b0) bad++;
         tick();
      end
      nvec++;
      if (bad != 0) begin
         nerr++;
         $display("FAIL basic_busy_window bad_cycles %0d want 0", bad);
      end
      nvec++;
      if (dn[2] !== 1'b1 || bz[2] !== 1'b0) begin
         nerr++;
         $display("FAIL basic_done got done=%b busy=%b want 1/0",
                  dn[2], bz[2]);
      end
      nvec++;
      if (df8 !== 8'h1E || bo[2] !== 1'b0) begin
         nerr++;
         $display("FAIL basic_result got %h/%b want 1e/0", df8, bo[2]);
      end
      tick();
      nvec++;
      if (dn[2] !== 1'b0 || df8 !== 8'h1E) begin
         nerr++;
         $display("FAIL basic_hold got done=%b diff=%h want 0/1e",
                  dn[2], df8);
      end
   endtask

   task automatic test_borrow();
      logic [7:0] d;
      logic       b;
      int         lat;
      run_op(2, 8'h00, 8'h01, 1'b0, d, b, lat);
      nvec++;
      if (lat != 8 || d !== 8'hFF || b !== 1'b1) begin
         nerr++;
         $display("FAIL borrow_0m1 got lat=%0d %h/%b want 8 ff/1",
                  lat, d, b);
      end
      run_op(2, 8'h10, 8'h0F, 1'b1, d, b, lat);
      nvec++;
      if (lat != 8 || d !== 8'h00 || b !== 1'b0) begin
         nerr++;
         $display("FAIL borrow_bin got lat=%0d %h/%b want 8 00/0",
                  lat, d, b);
      end
      tick();
   endtask

   task automatic test_ignore_busy();
      int lat;
      int extra;
      st[2] = 1'b1;
      av[2] = 8'h5A;
      bv[2] = 8'h3C;
      bi[2] = 1'b0;
      tick();
      st[2] = 1'b0;
      tick();
      tick();
      st[2] = 1'b1;
      av[2] = 8'hFF;
      bv[2] = 8'h00;
      tick();
      tick();
      st[2] = 1'b0;
      lat = 4;
      while (!dn[2] && lat < 40) begin
         tick();
         lat++;
      end
      nvec++;
      if (lat != 8 || df8 !== 8'h1E || bo[2] !== 1'b0) begin
         nerr++;
         $display("FAIL ignore_result got lat=%0d %h/%b want 8 1e/0",
                  lat, df8, bo[2]);
      end
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (dn[2] !== 1'b0 || bz[2] !== 1'b0) extra++;
      end
      nvec++;
      if (extra != 0) begin
         nerr++;
         $display("FAIL ignore_extra got %0d active cycles want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] oa [4] = '{8'h5A, 8'h3C, 8'h80, 8'h00};
      logic [7:0] ob [4] = '{8'h3C, 8'h5A, 8'h7F, 8'h00};
      logic       oi [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [7:0] ed [4] = '{8'h1E, 8'hE2, 8'h00, 8'hFF};
      logic       eb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      int n;
      st[2] = 1'b1;
      av[2] = oa[0];
      bv[2] = ob[0];
      bi[2] = oi[0];
      tick();
      for (int k = 0; k < 4; k++) begin
         if (k < 3) begin
            av[2] = oa[k+1];
            bv[2] = ob[k+1];
            bi[2] = oi[k+1];
         end else begin
            st[2] = 1'b0;
         end
         n = 0;
         while (!dn[2] && n < 20) begin
            tick();
            n++;
         end
         nvec++;
         if (n != 8 || df8 !== ed[k] || bo[2] !== eb[k]) begin
            nerr++;
            $display("FAIL b2b_%0d got lat=%0d %h/%b want 8 %h/%b",
                     k, n, df8, bo[2], ed[k], eb[k]);
         end
         tick();
      end
   endtask

   task automatic test_reset_abort();
      logic [7:0] d;
      logic       b;
      int         lat;
      int         extra;
      st[2] = 1'b1;
      av[2] = 8'h77;
      bv[2] = 8'h11;
      bi[2] = 1'b0;
      tick();
      st[2] = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      nvec++;
      if (bz[2] !== 1'b0 || dn[2] !== 1'b0) begin
         nerr++;
         $display("FAIL abort_flags got busy=%b done=%b want 0/0",
                  bz[2], dn[2]);
      end
      nvec++;
      if (df8 !== 8'h00 || bo[2] !== 1'b0) begin
         nerr++;
         $display("FAIL abort_outputs got %h/%b want 00/0", df8, bo[2]);
      end
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         if (dn[2] !== 1'b0 || bz[2] !== 1'b0) extra++;
         tick();
      end
      nvec++;
      if (extra != 0) begin
         nerr++;
         $display("FAIL abort_quiet got %0d active cycles want 0", extra);
      end
      run_op(2, 8'h33, 8'h44, 1'b0, d, b, lat);
      nvec++;
      if (lat != 8 || d !== 8'hEF || b !== 1'b1) begin
         nerr++;
         $display("FAIL abort_restart got lat=%0d %h/%b want 8 ef/1",
                  lat, d, b);
      end
      tick();
   endtask

   task automatic test_sweep();
      int         w [3] = '{1, 5, 8};
      logic [7:0] d;
      logic       b;
      int         lat;
      int         v;
      int         mask;
      logic [7:0] ea, eb2, ed;
      logic       ei, ebo;
      for (int k = 0; k < 3; k++) begin
         mask = (1 << w[k]) - 1;
         for (int i = 0; i < 1000; i++) begin
            ea  = 8'($urandom_range(mask));
            eb2 = 8'($urandom_range(mask));
            ei  = 1'($urandom_range(1));
            v   = int'(ea) - int'(eb2) - int'(ei);
            ed  = 8'(v & mask);
            ebo = (v < 0);
            run_op(k, ea, eb2, ei, d, b, lat);
            nvec++;
            if (lat != w[k] || d !== ed || b !== ebo) begin
               nerr++;
               $display("FAIL sweep_w%0d %h-%h-%b got lat=%0d %h/%b want %0d %h/%b",
                        w[k], ea, eb2, ei, lat, d, b, w[k], ed, ebo);
            end
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         st[k] = 1'b0;
         av[k] = 8'h00;
         bv[k] = 8'h00;
         bi[k] = 1'b0;
      end
      tick();
      tick();
      rst = 1'b0;
      test_reset();
      test_basic();
      test_borrow();
      test_ignore_busy();
      test_back_to_back();
      test_reset_abort();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
